// File: rtl/dht11_pkg.sv
// ---------------------------------------------------------------------------
// dht11_pkg
// Shared definitions for the DHT11 sensor emulator and the DHT11 controller:
// the emulator state encoding (also exported on the debug port), the frame
// length, the default protocol timings in microseconds, and the checksum
// helper.
// ---------------------------------------------------------------------------
package dht11_pkg;

    // The numeric values are visible on the emulator's debug output.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOST_L = 3'd1,
        ST_TURN   = 3'd2,
        ST_RESP_L = 3'd3,
        ST_RESP_H = 3'd4,
        ST_BIT_L  = 3'd5,
        ST_BIT_H  = 3'd6,
        ST_EOT    = 3'd7
    } dht_state_e;

    localparam int FRAME_BITS = 40;
    localparam int IDX_W      = $clog2(FRAME_BITS);

    // Default protocol timings (microseconds)
    localparam int DEF_START_MIN_US = 18_000;
    localparam int DEF_TURN_US      = 30;
    localparam int DEF_RESP_L_US    = 80;
    localparam int DEF_RESP_H_US    = 80;
    localparam int DEF_BIT_L_US     = 50;
    localparam int DEF_BIT0_H_US    = 28;
    localparam int DEF_BIT1_H_US    = 70;

    // 8-bit wrapping sum of the four data bytes
    function automatic logic [7:0] dht_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c,
                                                input logic [7:0] d);
        logic [9:0] s;
        s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return s[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// ---------------------------------------------------------------------------
// dht11_us_tick
// Microsecond prescaler. tick_o is high for one cycle out of every US_DIV
// cycles. A synchronous clear restarts the count so that the first tick
// after a clear comes exactly US_DIV cycles later.
// Ports:
//   clk_i   in  1  clock
//   rst_ni  in  1  asynchronous reset, active-low
//   clr_i   in  1  synchronous restart of the prescaler
//   tick_o  out 1  one-cycle microsecond tick
// ---------------------------------------------------------------------------
module dht11_us_tick #(
    parameter int US_DIV = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by clr_i: the owner derives its clear from this tick.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht11_sensor_emu.sv
// ---------------------------------------------------------------------------
// dht11_sensor_emu
// Responder end of the single-wire DHT11 protocol. Waits for a host start
// pulse on the open-drain dhtio line, then plays back the sync pattern and the
// 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
//
// Optional feature: define DHT11_EMU_CKSUM_ERR_EN to add the cksum_err_inj
// input; when it is 1 at the snapshot, the transmitted checksum is inverted.
//
// Ports:
//   clk            in    1  system clock
//   rst            in    1  asynchronous reset, active-low
//   hum_int        in    8  humidity integral byte
//   hum_dec        in    8  humidity decimal byte
//   temp_int       in    8  temperature integral byte
//   temp_dec       in    8  temperature decimal byte
//   cksum_err_inj  in    1  (DHT11_EMU_CKSUM_ERR_EN only) invert checksum
//   busy           out   1  start accepted until line released after EOT
//   start_det      out   1  one-cycle pulse on an accepted start request
//   frame_done     out   1  one-cycle pulse when the EOT low is released
//   debug          out   3  current state encoding
//   dhtio          inout 1  open-drain line: drives 0 or releases to z
// ---------------------------------------------------------------------------
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int TURN_US      = DEF_TURN_US,
    parameter int RESP_L_US    = DEF_RESP_L_US,
    parameter int RESP_H_US    = DEF_RESP_H_US,
    parameter int BIT_L_US     = DEF_BIT_L_US,
    parameter int BIT0_H_US    = DEF_BIT0_H_US,
    parameter int BIT1_H_US    = DEF_BIT1_H_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_EMU_CKSUM_ERR_EN
    input  logic       cksum_err_inj,
`endif
    output logic       busy,
    output logic       start_det,
    output logic       frame_done,
    output logic [2:0] debug,
    inout  wire        dhtio
);

    localparam int          US_DIV    = CLK_FREQ_HZ / 1_000_000;
    localparam logic [15:0] START_MIN = 16'(START_MIN_US);

    dht_state_e             state_q;
    logic [15:0]            us_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [FRAME_BITS-1:0]  frame_q;
    logic [1:0]             sync_q;
    logic                   drive_low_q;
    logic                   busy_q;
    logic                   start_det_q;
    logic                   frame_done_q;

    logic                   tick;
    logic                   ps_clr;
    logic                   line_hi;
    logic                   timed;
    logic                   phase_done;
    logic [15:0]            cur_len;
    logic                   err_inj;
    logic [7:0]             cksum_tx;
    logic [FRAME_BITS-1:0]  snap_frame;

    // Length in microseconds of each timed state; BIT_H depends on the bit.
    function automatic logic [15:0] phase_len(input dht_state_e st, input logic b);
        case (st)
            ST_TURN:   return 16'(TURN_US);
            ST_RESP_L: return 16'(RESP_L_US);
            ST_RESP_H: return 16'(RESP_H_US);
            ST_BIT_L:  return 16'(BIT_L_US);
            ST_BIT_H:  return b ? 16'(BIT1_H_US) : 16'(BIT0_H_US);
            ST_EOT:    return 16'(BIT_L_US);
            default:   return 16'd0;
        endcase
    endfunction

`ifdef DHT11_EMU_CKSUM_ERR_EN
    assign err_inj = cksum_err_inj;
`else
    assign err_inj = 1'b0;
`endif

    assign cksum_tx   = dht_checksum(hum_int, hum_dec, temp_int, temp_dec) ^ {8{err_inj}};
    assign snap_frame = {hum_int, hum_dec, temp_int, temp_dec, cksum_tx};

    assign line_hi    = sync_q[1];
    assign timed      = (state_q != ST_IDLE) && (state_q != ST_HOST_L);
    assign cur_len    = phase_len(state_q, frame_q[bit_idx_q]);
    assign phase_done = timed && tick && (us_q == cur_len - 16'd1);

    // The prescaler is restarted on every state entry so each phase lasts
    // exactly N*US_DIV cycles. Holding it clear in IDLE covers IDLE->HOST_L.
    assign ps_clr = (state_q == ST_IDLE) ||
                    ((state_q == ST_HOST_L) && line_hi) ||
                    phase_done;

    dht11_us_tick #(
        .US_DIV (US_DIV)
    ) u_us_tick (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (ps_clr),
        .tick_o (tick)
    );

    // Two-flop synchronizer. While in EOT it is preset high: our own drive is
    // still in the pipeline when the line is released, and IDLE must not
    // mistake it for a host start request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else if (state_q == ST_EOT) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], dhtio};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            us_q         <= '0;
            bit_idx_q    <= '0;
            frame_q      <= '0;
            drive_low_q  <= 1'b0;
            busy_q       <= 1'b0;
            start_det_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            start_det_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    us_q <= '0;
                    if (!line_hi) begin
                        state_q <= ST_HOST_L;
                    end
                end
                ST_HOST_L: begin
                    if (line_hi) begin
                        us_q <= '0;
                        if (us_q >= START_MIN) begin
                            state_q     <= ST_TURN;
                            busy_q      <= 1'b1;
                            start_det_q <= 1'b1;
                            frame_q     <= snap_frame;
                        end else begin
                            state_q <= ST_IDLE;   // too short: glitch
                        end
                    end else if (tick && (us_q < START_MIN)) begin
                        us_q <= us_q + 16'd1;
                    end
                end
                default: begin
                    if (phase_done) begin
                        us_q <= '0;
                        case (state_q)
                            ST_TURN: begin
                                state_q     <= ST_RESP_L;
                                drive_low_q <= 1'b1;
                            end
                            ST_RESP_L: begin
                                state_q     <= ST_RESP_H;
                                drive_low_q <= 1'b0;
                            end
                            ST_RESP_H: begin
                                state_q     <= ST_BIT_L;
                                drive_low_q <= 1'b1;
                                bit_idx_q   <= IDX_W'(FRAME_BITS - 1);
                            end
                            ST_BIT_L: begin
                                state_q     <= ST_BIT_H;
                                drive_low_q <= 1'b0;
                            end
                            ST_BIT_H: begin
                                drive_low_q <= 1'b1;
                                if (bit_idx_q == '0) begin
                                    state_q <= ST_EOT;
                                end else begin
                                    state_q   <= ST_BIT_L;
                                    bit_idx_q <= bit_idx_q - 1'b1;
                                end
                            end
                            default: begin
                                state_q      <= ST_IDLE;
                                drive_low_q  <= 1'b0;
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                            end
                        endcase
                    end else if (tick) begin
                        us_q <= us_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign dhtio      = drive_low_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign start_det  = start_det_q;
    assign frame_done = frame_done_q;
    assign debug      = state_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// ---------------------------------------------------------------------------
// tb_dht11_sensor_emu
// Bench for dht11_sensor_emu with a scaled clock (2 cycles per us) and a
// shortened start threshold (100 us). A host model pulls dhtio low or
// releases it; a pull-up supplies the high level. The frame is decoded from
// measured pulse widths.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dht11_sensor_emu;

    localparam int CPU = 2;           // clock cycles per microsecond
    localparam int TOL = 2;           // allowed pulse width error, cycles
    localparam int LIM = 400;         // bound on any single pulse, cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       host_low;
    logic       busy, start_det, frame_done;
    logic [2:0] debug;
    wire        dhtio;
`ifdef DHT11_EMU_CKSUM_ERR_EN
    logic       cksum_err_inj;
`endif

    int checks = 0;
    int errors = 0;
    int sd_cnt = 0;

    pullup (dhtio);
    assign dhtio = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_det === 1'b1) sd_cnt++;
    end

    dht11_sensor_emu #(
        .CLK_FREQ_HZ  (2_000_000),
        .START_MIN_US (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
`ifdef DHT11_EMU_CKSUM_ERR_EN
        .cksum_err_inj (cksum_err_inj),
`endif
        .busy       (busy),
        .start_det  (start_det),
        .frame_done (frame_done),
        .debug      (debug),
        .dhtio      (dhtio)
    );

    typedef struct {
        string      name;
        logic [7:0] hi, hd, ti, td;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit near(input int a, input int b);
        return (a >= b - TOL) && (a <= b + TOL);
    endfunction

    // Pulls the line low for low_us microseconds, releasing on a negedge.
    task automatic host_start(input int low_us);
        host_low = 1'b1;
        repeat (low_us * CPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Counts negedges while the line stays at lvl; ends on the first other level.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dhtio === lvl && n < LIM) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called on the negedge of host release.
    task automatic read_frame(output logic [39:0] f, output int turn, output int badw,
                              output logic fd, output logic bz);
        int w;
        f = '0; turn = 0; badw = 0; fd = 1'bx; bz = 1'bx;
        do begin
            @(negedge clk);
            turn++;
        end while (dhtio !== 1'b0 && turn < LIM);
        if (turn >= LIM) begin
            badw = 99;
            return;
        end
        measure(1'b0, w); if (!near(w, 80 * CPU)) badw++;
        measure(1'b1, w); if (!near(w, 80 * CPU)) badw++;
        for (int i = 39; i >= 0; i--) begin
            measure(1'b0, w); if (!near(w, 50 * CPU)) badw++;
            measure(1'b1, w);
            f[i] = (w > 49 * CPU);
            if (!near(w, f[i] ? 70 * CPU : 28 * CPU)) badw++;
        end
        measure(1'b0, w); if (!near(w, 50 * CPU)) badw++;
        fd = frame_done;
        bz = busy;
    endtask

    task automatic do_frame(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [39:0] exp, input bit mutate);
        logic [39:0] f;
        int turn, badw, sd0, k;
        logic fd, bz;
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
        sd0 = sd_cnt;
        k = 0;
        host_start(110);
        fork
            read_frame(f, turn, badw, fd, bz);
            if (mutate) begin
                while (start_det !== 1'b1 && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check({nm, "_busy_at_start"}, busy, 1);
                check({nm, "_state_at_start"}, debug, 2);
                @(negedge clk);
                hum_int = 8'd99;
            end
        join
        checks++;
        if (!(turn >= 63 - TOL && turn <= 63 + TOL)) begin
            errors++;
            $display("FAIL %s_turnaround: got %0d cycles, expected 63 +-%0d", nm, turn, TOL);
        end
        check({nm, "_bad_widths"}, badw, 0);
        check({nm, "_frame"}, f, exp);
        check({nm, "_frame_done"}, fd, 1);
        check({nm, "_busy_after"}, bz, 0);
        check({nm, "_start_det_count"}, sd_cnt - sd0, 1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int sd0, lows, k, nbh;
        logic [2:0] prev;

        vecs[0] = '{"basic",  8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4B};
        vecs[1] = '{"wrap",   8'hFF, 8'hFF, 8'hFF, 8'h01, 40'hFF_FF_FF_01_FE};
        vecs[2] = '{"mixed",  8'h12, 8'h34, 8'h56, 8'h78, 40'h12_34_56_78_14};
        vecs[3] = '{"zeros",  8'h00, 8'h00, 8'h00, 8'h00, 40'h00_00_00_00_00};

        rst = 1'b0; host_low = 1'b0;
        hum_int = '0; hum_dec = '0; temp_int = '0; temp_dec = '0;
`ifdef DHT11_EMU_CKSUM_ERR_EN
        cksum_err_inj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start_det", start_det, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_debug", debug, 0);
        check("rst_line", dhtio, 1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Short host pulse: rejected as a glitch
        sd0 = sd_cnt;
        host_low = 1'b1;
        repeat (50 * CPU) @(negedge clk);
        check("glitch_in_host_l", debug, 1);
        host_low = 1'b0;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (dhtio !== 1'b1) lows++;
        end
        check("glitch_line_low_cycles", lows, 0);
        check("glitch_debug", debug, 0);
        check("glitch_busy", busy, 0);
        check("glitch_start_det", sd_cnt - sd0, 0);

        for (int i = 0; i < 4; i++) begin
            do_frame(vecs[i].name, vecs[i].hi, vecs[i].hd, vecs[i].ti, vecs[i].td,
                     vecs[i].exp, 1'b0);
        end

        // Bytes change right after the snapshot
        do_frame("snapshot", 8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4B, 1'b1);

        // Reset while driving the response low: line released at once
        hum_int = 8'h32; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
        host_start(110);
        k = 0;
        while (dhtio !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("resp_l_reached", dhtio, 0);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_resp_l_line", dhtio, 1);
        check("rst_resp_l_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Reset during BIT_H of bit 20 (the 20th BIT_H phase)
        host_start(110);
        nbh = 0; k = 0; prev = 3'd0;
        while (nbh < 20 && k < 20000) begin
            @(negedge clk);
            k++;
            if (debug == 3'd6 && prev != 3'd6) nbh++;
            prev = debug;
        end
        check("bit20_reached", nbh, 20);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bit_h_line", dhtio, 1);
        check("rst_bit_h_busy", busy, 0);
        check("rst_bit_h_debug", debug, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        do_frame("after_reset", 8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4B, 1'b0);

`ifdef DHT11_EMU_CKSUM_ERR_EN
        cksum_err_inj = 1'b1;
        do_frame("cksum_inject", 8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_B4, 1'b0);
        cksum_err_inj = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
